// File: rtl/mfa_mem_responder_pkg.sv
// mfa_mem_responder_pkg: op3 codes, FSM encoding, access sizes and opcode decode for the MFA/MFC responder
package mfa_mem_responder_pkg;
    localparam logic [5:0] OP_LD   = 6'h00;
    localparam logic [5:0] OP_LDUB = 6'h01;
    localparam logic [5:0] OP_LDUH = 6'h02;
    localparam logic [5:0] OP_ST   = 6'h04;
    localparam logic [5:0] OP_STB  = 6'h05;
    localparam logic [5:0] OP_STH  = 6'h06;
    localparam logic [5:0] OP_LDSB = 6'h09;
    localparam logic [5:0] OP_LDSH = 6'h0A;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
    typedef struct packed {
        logic  legal;
        logic  store;
        logic  sgn;
        size_t size;
    } op_t;
    // op3[2] marks stores, op3[3] signed loads, op3[1:0] the size for every supported code
    function automatic op_t decode(input logic [5:0] op);
        op_t r;
        r.legal = op inside {OP_LD, OP_LDUB, OP_LDUH, OP_ST, OP_STB, OP_STH, OP_LDSB, OP_LDSH};
        r.store = op[2];
        r.sgn   = op[3];
        r.size  = op[1:0] == 2'd0 ? SZ_WORD : op[1] ? SZ_HALF : SZ_BYTE;
        return r;
    endfunction
endpackage

// File: rtl/mfa_mem_responder_lane_align.sv
// mfa_mem_responder_lane_align: big-endian load extract/extend and store lanes, byte enables, alignment check.
// rd/lane/be are ordered with the byte at A in the top position, A+3 at the bottom.
module mfa_mem_responder_lane_align
    import mfa_mem_responder_pkg::*;
(
    input  size_t       size,
    input  logic        sgn,
    input  logic [1:0]  addr,
    input  logic [31:0] rd,
    input  logic [31:0] wd,
    output logic [31:0] ld,
    output logic [31:0] lane,
    output logic [3:0]  be,
    output logic        misalign
);
    always_comb begin
        ld       = size == SZ_WORD ? rd :
                   size == SZ_HALF ? {{16{sgn & rd[31]}}, rd[31:16]} : {{24{sgn & rd[31]}}, rd[31:24]};
        lane     = size == SZ_WORD ? wd : size == SZ_HALF ? {wd[15:0], 16'h0} : {wd[7:0], 24'h0};
        be       = size == SZ_WORD ? 4'b1111 : size == SZ_HALF ? 4'b1100 : 4'b1000;
        misalign = size == SZ_WORD ? |addr : (size == SZ_HALF) && addr[0];
    end
endmodule

// File: rtl/mfa_mem_responder.sv
// mfa_mem_responder: MFA/MFC memory responder with wait states over a big-endian byte array.
// Requests are latched in IDLE; the array itself is never reset.
module mfa_mem_responder
    import mfa_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MFA,
    input  logic [5:0]        OPCODE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              MISALIGN,
    output logic              ILLOP
);
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [5:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din, rd, ld, lane;
    logic [3:0]        be;
    logic              misalign, we;
    op_t               d;
    logic [7:0]        mem [DEPTH];
    assign d  = decode(op);
    assign rd = {mem[addr], mem[addr + ADDR_W'(1)], mem[addr + ADDR_W'(2)], mem[addr + ADDR_W'(3)]};
    assign we = state == S_ACCESS && d.legal && !misalign && d.store;
    mfa_mem_responder_lane_align u_align (
        .size(d.size), .sgn(d.sgn), .addr(addr[1:0]), .rd(rd), .wd(din),
        .ld(ld), .lane(lane), .be(be), .misalign(misalign)
    );
    always_ff @(posedge Clk)
        for (int i = 0; i < 4; i++)
            if (we && be[3-i]) mem[addr + ADDR_W'(i)] <= lane[31-8*i -: 8];
    always_ff @(posedge Clk or posedge Clr)
        if (Clr) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= '0;
            addr     <= '0;
            din      <= '0;
            DataOut  <= '0;
            MFC      <= 1'b0;
            MISALIGN <= 1'b0;
            ILLOP    <= 1'b0;
        end else case (state)
            S_IDLE: if (MFA) begin
                op    <= OPCODE;
                addr  <= ADDRESS;
                din   <= DataIn;
                cnt   <= CW'(WAIT_CYCLES);
                state <= WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
            end
            S_WAIT: begin
                cnt   <= cnt - CW'(1);
                state <= !MFA ? S_IDLE : cnt == CW'(1) ? S_ACCESS : S_WAIT;
            end
            S_ACCESS: begin
                MFC      <= 1'b1;
                ILLOP    <= !d.legal;
                MISALIGN <= d.legal && misalign;
                if (d.legal && !misalign && !d.store) DataOut <= ld;
                state    <= S_DONE;
            end
            default: if (!MFA) begin
                MFC      <= 1'b0;
                MISALIGN <= 1'b0;
                ILLOP    <= 1'b0;
                state    <= S_IDLE;
            end
        endcase
endmodule

// File: tb/tb_mfa_mem_responder.sv
// tb_mfa_mem_responder: directed vector table, hand sequences for abort/reset, randomized ops vs byte-array model.
module tb_mfa_mem_responder;
    localparam int W = 2;
    typedef struct {
        logic [5:0]  op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_do;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;
    logic        clk = 0, clr = 1, mfa = 0;
    logic [5:0]  opcode = 0;
    logic [7:0]  address = 0;
    logic [31:0] data_in = 0, data_out;
    logic        mfc, misalign, illop;
    int          n_checks = 0, n_fail = 0;
    logic [7:0]  mdl [256];
    logic [31:0] mdl_do = 0;
    logic        mdl_mis, mdl_ill;
    logic [31:0] got_do;
    logic        got_mis, got_ill;
    vec_t        tbl [26];

    mfa_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(W)) dut (
        .Clk(clk), .Clr(clr), .MFA(mfa), .OPCODE(opcode), .ADDRESS(address), .DataIn(data_in),
        .DataOut(data_out), .MFC(mfc), .MISALIGN(misalign), .ILLOP(illop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bytes moved one at a time, big-endian, value extended by arithmetic
    task automatic model(input logic [5:0] op, input logic [7:0] a, input logic [31:0] dat);
        int nb;
        bit st, sg;
        longint v;
        nb = 0; st = 0; sg = 0;
        case (op)
            6'h00: nb = 4;
            6'h01: nb = 1;
            6'h02: nb = 2;
            6'h04: begin nb = 4; st = 1; end
            6'h05: begin nb = 1; st = 1; end
            6'h06: begin nb = 2; st = 1; end
            6'h09: begin nb = 1; sg = 1; end
            6'h0A: begin nb = 2; sg = 1; end
            default: nb = 0;
        endcase
        mdl_ill = nb == 0;
        mdl_mis = nb != 0 && (int'(a) % nb) != 0;
        if (mdl_ill || mdl_mis) return;
        if (st) begin
            for (int i = 0; i < nb; i++) mdl[8'(int'(a) + i)] = 8'(dat >> (8 * (nb - 1 - i)));
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v * 256 + longint'(mdl[8'(int'(a) + i)]);
            if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            mdl_do = 32'(v);
        end
    endtask

    task automatic run_op(input logic [5:0] op, input logic [7:0] a, input logic [31:0] dat);
        int edges;
        @(negedge clk);
        opcode = op; address = a; data_in = dat; mfa = 1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin opcode = ~op; address = ~a; data_in = ~dat; end
        end while (!mfc && edges < 20);
        check("mfc_latency", edges, W + 2);
        got_do = data_out; got_mis = misalign; got_ill = illop;
        model(op, a, dat);
        @(posedge clk); #1;
        check("done_hold", {mfc, misalign, illop, data_out}, {1'b1, got_mis, got_ill, got_do});
        @(negedge clk);
        mfa = 0;
        @(posedge clk); #1;
        check("mfc_release", {mfc, misalign, illop}, 3'b000);
    endtask

    initial begin
        logic [5:0] rop;
        logic [7:0] ra;
        logic [5:0] legal_ops [8];
        legal_ops = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0A};
        tbl[0]  = '{6'h04, 8'h04, 32'hA2044012, 32'h00000000, 0, 0};
        tbl[1]  = '{6'h00, 8'h04, 32'h0,        32'hA2044012, 0, 0};
        tbl[2]  = '{6'h05, 8'h09, 32'h00000085, 32'hA2044012, 0, 0};
        tbl[3]  = '{6'h09, 8'h09, 32'h0,        32'hFFFFFF85, 0, 0};
        tbl[4]  = '{6'h01, 8'h09, 32'h0,        32'h00000085, 0, 0};
        tbl[5]  = '{6'h02, 8'h08, 32'h0,        32'h00000085, 0, 0};
        tbl[6]  = '{6'h00, 8'h06, 32'h0,        32'h00000085, 1, 0};
        tbl[7]  = '{6'h06, 8'h03, 32'h0000ABCD, 32'h00000085, 1, 0};
        tbl[8]  = '{6'h00, 8'h00, 32'h0,        32'h00000000, 0, 0};
        tbl[9]  = '{6'h00, 8'h04, 32'h0,        32'hA2044012, 0, 0};
        tbl[10] = '{6'h08, 8'h04, 32'hFFFFFFFF, 32'hA2044012, 0, 1};
        tbl[11] = '{6'h00, 8'h04, 32'h0,        32'hA2044012, 0, 0};
        tbl[12] = '{6'h06, 8'h0C, 32'h00008001, 32'hA2044012, 0, 0};
        tbl[13] = '{6'h0A, 8'h0C, 32'h0,        32'hFFFF8001, 0, 0};
        tbl[14] = '{6'h02, 8'h0C, 32'h0,        32'h00008001, 0, 0};
        tbl[15] = '{6'h00, 8'h0C, 32'h0,        32'h80010000, 0, 0};
        tbl[16] = '{6'h02, 8'h09, 32'h0,        32'h80010000, 1, 0};
        tbl[17] = '{6'h03, 8'h00, 32'h0,        32'h80010000, 0, 1};
        tbl[18] = '{6'h3F, 8'h01, 32'h0,        32'h80010000, 0, 1};
        tbl[19] = '{6'h05, 8'hFF, 32'h00000077, 32'h80010000, 0, 0};
        tbl[20] = '{6'h01, 8'hFF, 32'h0,        32'h00000077, 0, 0};
        tbl[21] = '{6'h00, 8'hFC, 32'h0,        32'h00000077, 0, 0};
        tbl[22] = '{6'h0A, 8'h08, 32'h0,        32'h00000085, 0, 0};
        tbl[23] = '{6'h04, 8'h01, 32'h12345678, 32'h00000085, 1, 0};
        tbl[24] = '{6'h09, 8'h04, 32'h0,        32'hFFFFFFA2, 0, 0};
        tbl[25] = '{6'h0A, 8'h04, 32'h0,        32'hFFFFA204, 0, 0};

        #1;
        check("reset_outputs", {data_out, mfc, misalign, illop}, 35'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 0;
        for (int a = 0; a < 256; a += 4) run_op(6'h04, 8'(a), 32'h0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_data", i), got_do, tbl[i].exp_do);
            check($sformatf("tbl%0d_flags", i), {got_mis, got_ill}, {tbl[i].exp_mis, tbl[i].exp_ill});
        end

        // Request withdrawn during wait states: no completion, no write
        @(negedge clk);
        opcode = 6'h04; address = 8'h10; data_in = 32'hDEADBEEF; mfa = 1;
        @(posedge clk); #1;
        @(negedge clk);
        mfa = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            check("abort_no_mfc", mfc, 0);
        end
        run_op(6'h00, 8'h10, 32'h0);
        check("abort_ld", got_do, 32'h0);

        // Reset while the store is in its access cycle
        @(negedge clk);
        opcode = 6'h04; address = 8'h14; data_in = 32'h11223344; mfa = 1;
        repeat (W + 1) @(posedge clk);
        #1;
        clr = 1;
        #1;
        check("clr_outputs", {mfc, data_out}, 33'h0);
        @(negedge clk);
        mfa = 0; clr = 0; mdl_do = 0;
        @(posedge clk); #1;
        check("clr_idle", mfc, 0);
        run_op(6'h00, 8'h14, 32'h0);
        check("clr_ld", got_do, 32'h0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 8) == 0) begin
                do rop = 6'($urandom); while (rop inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0A});
            end else rop = legal_ops[$urandom_range(0, 7)];
            ra = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            run_op(rop, ra, $urandom);
            check("rnd_data", got_do, mdl_do);
            check("rnd_flags", {got_mis, got_ill}, {mdl_mis, mdl_ill});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
